mem_stage: RTL and testbench

- Memory-access stage of the 5-stage pipeline. Sits directly downstream of the execute stage and consumes its control bits, destination register, store data and ALU result.
- Holds the EXE/MEM pipeline register and drives a word-wide data-memory bus with a req/ack handshake. Supports byte and word access.
- Stalls upstream while an access is outstanding. Produces the registered MEM/WB outputs for write-back.

---
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: EXE/MEM register, req/ack data-memory bus, MEM/WB register.
// Optional misaligned word-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_MEM_dmemWe,
    input  logic                   i_MEM_regWe,
    input  logic                   i_MEM_sByte,
    input  logic                   i_MEM_sWRD,
    input  logic [4:0]             i_MEM_WRA,
    input  logic [31:0]            i_MEM_rd2,
    input  logic [31:0]            i_MEM_aluOut,
    input  logic [31:0]            i_MEM_dRdata,
    input  logic                   i_MEM_dAck,
    output logic                   o_MEM_stall,
    output logic                   o_MEM_dReq,
    output logic                   o_MEM_dWe,
    output logic [31:0]            o_MEM_dAddr,
    output logic [31:0]            o_MEM_dWdata,
    output logic [3:0]             o_MEM_dBe,
    output logic                   o_MEM_regWe,
    output logic [4:0]             o_MEM_WRA,
    output logic [31:0]            o_MEM_wd,
    output logic                   o_MEM_trap,
    output logic [STALL_CNT_W-1:0] o_MEM_stallCnt
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic        r_dmem_we, r_reg_we, r_s_byte, r_s_wrd;
    logic [4:0]  r_wra;
    logic [31:0] r_rd2, r_alu;
    logic        memop, misalign, is_load;
    logic [7:0]  ld_byte;
    logic [31:0] ld_data, wd_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dmem_we <= 1'b0;
            r_reg_we  <= 1'b0;
            r_s_byte  <= 1'b0;
            r_s_wrd   <= 1'b0;
            r_wra     <= '0;
            r_rd2     <= '0;
            r_alu     <= '0;
        end else if (!o_MEM_stall) begin
            r_dmem_we <= i_MEM_dmemWe;
            r_reg_we  <= i_MEM_regWe;
            r_s_byte  <= i_MEM_sByte;
            r_s_wrd   <= i_MEM_sWRD;
            r_wra     <= i_MEM_WRA;
            r_rd2     <= i_MEM_rd2;
            r_alu     <= i_MEM_aluOut;
        end
    end

    assign memop   = r_dmem_we | r_s_wrd;
    assign is_load = r_s_wrd & ~r_dmem_we;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = memop & ~r_s_byte & (|r_alu[1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) o_MEM_trap <= 1'b0;
        else       o_MEM_trap <= misalign;
    end
`else
    assign misalign   = 1'b0;
    assign o_MEM_trap = 1'b0;
`endif

    // The register holds while stalled, so the request stays up in WAIT.
    assign o_MEM_dReq   = memop & ~misalign;
    assign o_MEM_stall  = o_MEM_dReq & ~i_MEM_dAck;
    assign o_MEM_dWe    = r_dmem_we;
    assign o_MEM_dAddr  = {r_alu[31:2], 2'b00};
    assign o_MEM_dWdata = r_s_byte ? {4{r_rd2[7:0]}} : r_rd2;
    assign o_MEM_dBe    = (r_dmem_we & r_s_byte) ? (4'b0001 << r_alu[1:0]) : 4'hF;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (o_MEM_dReq && !i_MEM_dAck) state_nxt = S_WAIT;
            S_WAIT: if (i_MEM_dAck) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ld_byte = i_MEM_dRdata[7:0];
        unique case (r_alu[1:0])
            2'd0: ld_byte = i_MEM_dRdata[7:0];
            2'd1: ld_byte = i_MEM_dRdata[15:8];
            2'd2: ld_byte = i_MEM_dRdata[23:16];
            2'd3: ld_byte = i_MEM_dRdata[31:24];
            default: ld_byte = i_MEM_dRdata[7:0];
        endcase
        ld_data = r_s_byte ? {{24{ld_byte[7]}}, ld_byte} : i_MEM_dRdata;
        wd_nxt  = is_load ? ld_data : r_alu;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_MEM_regWe <= 1'b0;
            o_MEM_WRA   <= '0;
            o_MEM_wd    <= '0;
        end else if (o_MEM_stall || misalign) begin
            o_MEM_regWe <= 1'b0;
            o_MEM_WRA   <= '0;
            o_MEM_wd    <= '0;
        end else begin
            o_MEM_regWe <= r_reg_we & ~r_dmem_we;
            o_MEM_WRA   <= r_wra;
            o_MEM_wd    <= wd_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            o_MEM_stallCnt <= '0;
        else if (o_MEM_stall && o_MEM_stallCnt != '1)
            o_MEM_stallCnt <= o_MEM_stallCnt + 1'b1;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Misalign section follows MEM_MISALIGN_TRAP_EN like the design.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dmem_we, reg_we, s_byte, s_wrd;
    logic [4:0]  wra;
    logic [31:0] rd2, alu_out, d_rdata;
    logic        d_ack;
    logic        stall, d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        o_reg_we;
    logic [4:0]  o_wra;
    logic [31:0] o_wd;
    logic        trap;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .i_MEM_dmemWe(dmem_we), .i_MEM_regWe(reg_we),
        .i_MEM_sByte(s_byte), .i_MEM_sWRD(s_wrd),
        .i_MEM_WRA(wra), .i_MEM_rd2(rd2), .i_MEM_aluOut(alu_out),
        .i_MEM_dRdata(d_rdata), .i_MEM_dAck(d_ack),
        .o_MEM_stall(stall), .o_MEM_dReq(d_req), .o_MEM_dWe(d_we),
        .o_MEM_dAddr(d_addr), .o_MEM_dWdata(d_wdata), .o_MEM_dBe(d_be),
        .o_MEM_regWe(o_reg_we), .o_MEM_WRA(o_wra), .o_MEM_wd(o_wd),
        .o_MEM_trap(trap), .o_MEM_stallCnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic rwe, input logic sb,
                         input logic swrd, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] alu);
        dmem_we = we; reg_we = rwe; s_byte = sb; s_wrd = swrd;
        wra = a; rd2 = d; alu_out = alu;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        d_ack = 1'b0;
        d_rdata = 32'h0;
        bubble();
        #3;
        chk("rst_dReq", {31'b0, d_req}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_regWe", {31'b0, o_reg_we}, 32'd0);
        chk("rst_wd", o_wd, 32'd0);
        chk("rst_cnt", {16'b0, stall_cnt}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        #10;
        rstn = 1'b1;
        tick();

        // ALU op
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0, 32'h55);
        tick();
        chk("alu_dReq", {31'b0, d_req}, 32'd0);
        bubble();
        tick();
        chk("alu_regWe", {31'b0, o_reg_we}, 32'd1);
        chk("alu_WRA", {27'b0, o_wra}, 32'd3);
        chk("alu_wd", o_wd, 32'h55);

        // Word load with 3 wait cycles
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h100);
        tick();
        bubble();
        for (int i = 0; i < 3; i++) begin
            chk("wl_dReq", {31'b0, d_req}, 32'd1);
            chk("wl_stall", {31'b0, stall}, 32'd1);
            chk("wl_addr", d_addr, 32'h100);
            chk("wl_be", {28'b0, d_be}, 32'hF);
            chk("wl_dWe", {31'b0, d_we}, 32'd0);
            tick();
            chk("wl_bubble", {31'b0, o_reg_we}, 32'd0);
        end
        d_ack = 1'b1;
        d_rdata = 32'hDEADBEEF;
        #1;
        chk("wl_ack_stall", {31'b0, stall}, 32'd0);
        chk("wl_cnt", {16'b0, stall_cnt}, 32'd3);
        tick();
        d_ack = 1'b0;
        chk("wl_regWe", {31'b0, o_reg_we}, 32'd1);
        chk("wl_WRA", {27'b0, o_wra}, 32'd5);
        chk("wl_wd", o_wd, 32'hDEADBEEF);
        chk("wl_idle_dReq", {31'b0, d_req}, 32'd0);

        // Byte store, zero-wait
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'hA5, 32'h203);
        d_ack = 1'b1;
        tick();
        chk("bs_dReq", {31'b0, d_req}, 32'd1);
        chk("bs_be", {28'b0, d_be}, 32'h8);
        chk("bs_wdata", d_wdata, 32'hA5A5A5A5);
        chk("bs_dWe", {31'b0, d_we}, 32'd1);
        chk("bs_addr", d_addr, 32'h200);
        chk("bs_stall", {31'b0, stall}, 32'd0);
        // Word store, zero-wait, back-to-back
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h11223344, 32'h40);
        tick();
        chk("bs_regWe", {31'b0, o_reg_we}, 32'd0);
        chk("ws_be", {28'b0, d_be}, 32'hF);
        chk("ws_wdata", d_wdata, 32'h11223344);
        chk("ws_stall", {31'b0, stall}, 32'd0);

        // Byte loads, immediate ack
        d_rdata = 32'h12348056;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 32'h101);
        tick();
        chk("ws_regWe", {31'b0, o_reg_we}, 32'd0);
        chk("bl1_stall", {31'b0, stall}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h102);
        tick();
        chk("bl1_wd", o_wd, 32'hFFFFFF80);
        chk("bl1_WRA", {27'b0, o_wra}, 32'd6);
        bubble();
        tick();
        chk("bl2_wd", o_wd, 32'h00000034);
        chk("bl2_regWe", {31'b0, o_reg_we}, 32'd1);
        chk("nostall_cnt", {16'b0, stall_cnt}, 32'd3);
        d_ack = 1'b0;

        // Misaligned word load
        d_rdata = 32'hCAFEF00D;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0, 32'h102);
        tick();
        bubble();
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_dReq", {31'b0, d_req}, 32'd0);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("mis_trap", {31'b0, trap}, 32'd1);
        chk("mis_regWe", {31'b0, o_reg_we}, 32'd0);
        tick();
        chk("mis_trap_drop", {31'b0, trap}, 32'd0);
`else
        chk("mis_dReq", {31'b0, d_req}, 32'd1);
        chk("mis_addr", d_addr, 32'h100);
        d_ack = 1'b1;
        #1;
        chk("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        d_ack = 1'b0;
        chk("mis_wd", o_wd, 32'hCAFEF00D);
        chk("mis_regWe", {31'b0, o_reg_we}, 32'd1);
        chk("mis_trap", {31'b0, trap}, 32'd0);
`endif

        // Reset during WAIT
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h300);
        tick();
        bubble();
        chk("rw_dReq", {31'b0, d_req}, 32'd1);
        tick();
        chk("rw_cnt_pre", {16'b0, stall_cnt}, 32'd4);
        #2;
        rstn = 1'b0;
        #1;
        chk("rw_dReq0", {31'b0, d_req}, 32'd0);
        chk("rw_stall0", {31'b0, stall}, 32'd0);
        chk("rw_addr0", d_addr, 32'd0);
        chk("rw_cnt0", {16'b0, stall_cnt}, 32'd0);
        chk("rw_regWe0", {31'b0, o_reg_we}, 32'd0);
        #3;
        rstn = 1'b1;
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0, 32'h1234);
        tick();
        chk("post_dReq", {31'b0, d_req}, 32'd0);
        bubble();
        tick();
        chk("post_regWe", {31'b0, o_reg_we}, 32'd1);
        chk("post_WRA", {27'b0, o_wra}, 32'd7);
        chk("post_wd", o_wd, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
